// File: rtl/psram_responder.sv
// rtl/psram_responder.sv - octal PSRAM target model decoding memCtrl CS/SCLK/DATA into an internal byte array.
// Define PSRAM_RESP_PAGE_WRAP_EN to wrap burst addresses within a 1 KiB page.
module psram_responder #(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 4,
    parameter logic [7:0]  INIT_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_psram_data,
    output logic [7:0] o_psram_data,
    output logic       o_psram_oe,
    output logic       o_busy,
    output logic [7:0] o_last_cmd,
    output logic       o_err
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef PSRAM_RESP_PAGE_WRAP_EN
    localparam int WRAP_W = (ADDR_W < 10) ? ADDR_W : 10;
`else
    localparam int WRAP_W = ADDR_W;
`endif
    localparam logic [23:0] WRAP_MASK = 24'((32'd1 << WRAP_W) - 32'd1);
    localparam logic [7:0]  LAST_DUMMY = 8'(LATENCY - 1);
    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_DUMMY,
        S_RDATA,
        S_IGNORE
    } state_t;

    // Contents survive reset; only configuration loads INIT_BYTE.
    logic [7:0] mem [DEPTH] = '{default: INIT_BYTE};

    logic       cs_meta_q, cs_s_q, cs_prev_q;
    logic       sclk_meta_q, sclk_s_q, sclk_prev_q;
    logic [7:0] data_meta_q, data_s_q;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  addr_cnt_q, addr_cnt_d;
    logic [7:0]  dummy_cnt_q, dummy_cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        err_q, err_d;

    logic              sclk_rise, sclk_fall, cs_fall;
    logic [23:0]       addr_full;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    function automatic logic [23:0] addr_inc(input logic [23:0] a);
        return (a & ~WRAP_MASK) | ((a + 24'd1) & WRAP_MASK);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_s_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
            data_meta_q <= 8'h00;
            data_s_q    <= 8'h00;
        end else begin
            cs_meta_q   <= i_psram_cs;
            cs_s_q      <= cs_meta_q;
            cs_prev_q   <= cs_s_q;
            sclk_meta_q <= i_psram_sclk;
            sclk_s_q    <= sclk_meta_q;
            sclk_prev_q <= sclk_s_q;
            data_meta_q <= i_psram_data;
            data_s_q    <= data_meta_q;
        end
    end

    assign sclk_rise = sclk_s_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s_q & sclk_prev_q;
    assign cs_fall   = ~cs_s_q & cs_prev_q;
    assign addr_full = {addr_q[15:0], data_s_q};

    // Zero-latency reads prefetch from the address completing on this very rise.
    assign rd_addr = (state_q == S_ADDR) ? addr_full[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
    assign rd_byte = mem[rd_addr];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_cnt_d  = addr_cnt_q;
        dummy_cnt_d = dummy_cnt_q;
        rdata_d     = rdata_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        last_cmd_d  = last_cmd_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q[ADDR_W-1:0];
        mem_wdata   = data_s_q;

        if (state_q != S_IDLE && cs_s_q) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d     = S_CMD;
                        busy_d      = 1'b1;
                        addr_d      = 24'd0;
                        addr_cnt_d  = 2'd0;
                        dummy_cnt_d = 8'd0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        last_cmd_d = data_s_q;
                        if (data_s_q == CMD_WRITE || data_s_q == CMD_READ) begin
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        addr_d     = addr_full;
                        addr_cnt_d = addr_cnt_q + 2'd1;
                        if (addr_cnt_q == 2'd2) begin
                            if (last_cmd_q != CMD_READ) begin
                                state_d = S_WDATA;
                            end else if (LATENCY == 0) begin
                                rdata_d = rd_byte;
                                oe_d    = 1'b1;
                                addr_d  = addr_inc(addr_full);
                                state_d = S_RDATA;
                            end else begin
                                state_d = S_DUMMY;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sclk_rise) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc(addr_q);
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise) begin
                        if (dummy_cnt_q == LAST_DUMMY) begin
                            rdata_d = rd_byte;
                            oe_d    = 1'b1;
                            addr_d  = addr_inc(addr_q);
                            state_d = S_RDATA;
                        end else begin
                            dummy_cnt_d = dummy_cnt_q + 8'd1;
                        end
                    end
                end
                S_RDATA: begin
                    // Loaded after the fall so the byte is settled before the next rise.
                    if (sclk_fall) begin
                        rdata_d = rd_byte;
                        addr_d  = addr_inc(addr_q);
                    end
                end
                S_IGNORE: begin
                end
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 24'd0;
            addr_cnt_q  <= 2'd0;
            dummy_cnt_q <= 8'd0;
            rdata_q     <= 8'h00;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            last_cmd_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr_cnt_q  <= addr_cnt_d;
            dummy_cnt_q <= dummy_cnt_d;
            rdata_q     <= rdata_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            last_cmd_q  <= last_cmd_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_psram_data = rdata_q;
    assign o_psram_oe   = oe_q;
    assign o_busy       = busy_q;
    assign o_last_cmd   = last_cmd_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_psram_responder.sv
// tb/tb_psram_responder.sv - randomized self-checking bench for psram_responder against a byte-array model.
module tb_psram_responder;

    localparam int ADDR_W  = 12;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 1 << ADDR_W;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       sclk;
    logic [7:0] din;
    logic [7:0] o_psram_data;
    logic       o_psram_oe;
    logic       o_busy;
    logic [7:0] o_last_cmd;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] wbuf [16];
    logic [7:0] rbuf [16];
    logic       roe  [16];
    logic       pre_oe;
    int         busy_lat;

    psram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .INIT_BYTE(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_psram_cs   (cs),
        .i_psram_sclk (sclk),
        .i_psram_data (din),
        .o_psram_data (o_psram_data),
        .o_psram_oe   (o_psram_oe),
        .o_busy       (o_busy),
        .o_last_cmd   (o_last_cmd),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // Array index of the k-th byte of a burst starting at 24-bit address a.
    function automatic int model_idx(input logic [23:0] a, input int k);
        int base;
        base = int'(a) % DEPTH;
`ifdef PSRAM_RESP_PAGE_WRAP_EN
        return (base / 1024) * 1024 + ((base % 1024) + k) % 1024;
`else
        return (base + k) % DEPTH;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b, output logic [7:0] rd, output logic oe);
        din = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        rd = o_psram_data;
        oe = o_psram_oe;
        sclk = 1'b0;
    endtask

    task automatic cs_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_end(output int lat);
        tick(4);
        cs = 1'b1;
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (!o_busy) begin
                lat = k;
                break;
            end
        end
        tick(4);
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        logic [7:0] rd;
        logic       oe;
        cs_start();
        pulse(8'h02, rd, oe);
        pulse(a[23:16], rd, oe);
        pulse(a[15:8], rd, oe);
        pulse(a[7:0], rd, oe);
        for (int i = 0; i < n; i++) begin
            pulse(wbuf[i], rd, oe);
            ref_mem[model_idx(a, i)] = wbuf[i];
        end
        cs_end(busy_lat);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] rd;
        logic [7:0] b;
        logic       oe;
        int         k;
        cs_start();
        pulse(8'h03, rd, oe);
        pre_oe = 1'b0;
        for (int p = 1; p <= 3 + LATENCY + n - 1; p++) begin
            b = (p == 1) ? a[23:16] : (p == 2) ? a[15:8] : (p == 3) ? a[7:0] : 8'h00;
            pulse(b, rd, oe);
            k = p - 3 - LATENCY;
            if (k >= 0) begin
                rbuf[k] = rd;
                roe[k]  = oe;
            end
            if (p == 3 + LATENCY - 1) pre_oe = oe;
        end
        cs_end(busy_lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        din   = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(5);
        reset = 1'b1;
        #1;
        total++; if (o_psram_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_psram_data); end
        total++; if (o_psram_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", o_psram_oe); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_last_cmd !== 8'h00) begin bad++; $display("FAIL reset_last_cmd got=%h exp=00", o_last_cmd); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
        tick(2);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_write_read();
        wbuf[0] = 8'h14;
        do_write(24'h00C000, 1);
        do_read(24'h00C000, 1);
        total++; if (rbuf[0] !== 8'h14) begin bad++; $display("FAIL wr_rd_byte got=%h exp=14", rbuf[0]); end
        total++; if (roe[0] !== 1'b1) begin bad++; $display("FAIL wr_rd_oe_after_dummy got=%b exp=1", roe[0]); end
        total++; if (pre_oe !== 1'b0) begin bad++; $display("FAIL wr_rd_oe_early got=%b exp=0", pre_oe); end
        total++; if (busy_lat < 2 || busy_lat > 3) begin bad++; $display("FAIL wr_rd_busy_drop got=%0d exp=2..3", busy_lat); end
        total++; if (o_last_cmd !== 8'h03) begin bad++; $display("FAIL wr_rd_last_cmd got=%h exp=03", o_last_cmd); end
        total++; if (o_psram_oe !== 1'b0) begin bad++; $display("FAIL wr_rd_oe_release got=%b exp=0", o_psram_oe); end
    endtask

    task automatic test_wrap();
        logic [23:0] start;
`ifdef PSRAM_RESP_PAGE_WRAP_EN
        start = 24'h0003FE;
`else
        start = 24'h000FFE;
`endif
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        do_write(start, 4);
        do_read(start, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rbuf[i] !== 8'hA0 + 8'(i)) begin
                bad++; $display("FAIL wrap_read[%0d] got=%h exp=%h", i, rbuf[i], 8'hA0 + 8'(i));
            end
        end
        do_read(24'h000000, 2);
        total++; if (rbuf[0] !== 8'hA2) begin bad++; $display("FAIL wrap_land0 got=%h exp=a2", rbuf[0]); end
        total++; if (rbuf[1] !== 8'hA3) begin bad++; $display("FAIL wrap_land1 got=%h exp=a3", rbuf[1]); end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] rd;
        logic       oe;
        logic       any_oe;
        logic [7:0] junk [5];
        junk[0] = 8'h00; junk[1] = 8'h00; junk[2] = 8'h00; junk[3] = 8'hAA; junk[4] = 8'hBB;
        any_oe = 1'b0;
        cs_start();
        pulse(8'h55, rd, oe);
        any_oe |= oe;
        for (int i = 0; i < 5; i++) begin
            pulse(junk[i], rd, oe);
            any_oe |= oe;
        end
        cs_end(busy_lat);
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL unk_err got=%b exp=1", o_err); end
        total++; if (o_last_cmd !== 8'h55) begin bad++; $display("FAIL unk_last_cmd got=%h exp=55", o_last_cmd); end
        total++; if (any_oe !== 1'b0) begin bad++; $display("FAIL unk_oe got=%b exp=0", any_oe); end
        do_read(24'h000000, 2);
        total++; if (rbuf[0] !== ref_mem[0]) begin bad++; $display("FAIL unk_mem0 got=%h exp=%h", rbuf[0], ref_mem[0]); end
        total++; if (rbuf[1] !== ref_mem[1]) begin bad++; $display("FAIL unk_mem1 got=%h exp=%h", rbuf[1], ref_mem[1]); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL unk_err_sticky got=%b exp=1", o_err); end
    endtask

    task automatic test_abort_addr();
        logic [7:0] rd;
        logic       oe;
        cs_start();
        pulse(8'h03, rd, oe);
        pulse(8'h00, rd, oe);
        pulse(8'h00, rd, oe);
        cs_end(busy_lat);
        total++; if (busy_lat < 2 || busy_lat > 3) begin bad++; $display("FAIL abort_busy_drop got=%0d exp=2..3", busy_lat); end
        do_read(24'h000000, 1);
        total++; if (rbuf[0] !== ref_mem[0]) begin bad++; $display("FAIL abort_read0 got=%h exp=%h", rbuf[0], ref_mem[0]); end
    endtask

    task automatic test_alias();
        wbuf[0] = 8'h7E;
        do_write(24'h010010, 1);
        do_read(24'h000010, 1);
        total++; if (rbuf[0] !== 8'h7E) begin bad++; $display("FAIL alias_read got=%h exp=7e", rbuf[0]); end
    endtask

    task automatic test_random();
        logic [23:0] a;
        int          n;
        for (int t = 0; t < 8; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n);
            do_read(a, n);
            for (int i = 0; i < n; i++) begin
                total++;
                if (rbuf[i] !== ref_mem[model_idx(a, i)]) begin
                    bad++; $display("FAIL rand_read t=%0d i=%0d got=%h exp=%h", t, i, rbuf[i], ref_mem[model_idx(a, i)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        logic       oe;
        logic [23:0] a;
        a = 24'h00C000;
        cs_start();
        pulse(8'h03, rd, oe);
        pulse(a[23:16], rd, oe);
        pulse(a[15:8], rd, oe);
        pulse(a[7:0], rd, oe);
        for (int d = 0; d < LATENCY; d++) pulse(8'h00, rd, oe);
        total++; if (oe !== 1'b1) begin bad++; $display("FAIL rstmid_oe_before got=%b exp=1", oe); end
        tick(1);
        reset = 1'b1;
        #1;
        total++; if (o_psram_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe got=%b exp=0", o_psram_oe); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", o_err); end
        cs = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        do_read(a, 1);
        total++; if (rbuf[0] !== ref_mem[model_idx(a, 0)]) begin bad++; $display("FAIL rstmid_persist got=%h exp=%h", rbuf[0], ref_mem[model_idx(a, 0)]); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_wrap();
        test_unknown_cmd();
        test_abort_addr();
        test_alias();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psram_responder.md
Name: psram_responder

Overview:
- Synthesizable target-side model of the octal PSRAM bus that memCtrl drives: it decodes the memCtrl command/address/data stream on CS/SCLK/DATA[7:0] and serves writes and reads from an internal byte array.
- Used in simulation benches and as an on-FPGA loopback target, so memCtrl and the top-level RAM self-test can run without the physical PSRAM.
- Runs on one fast system clock that oversamples SCLK; it is not clocked by SCLK.

Parameters:
ADDR_W, 12, internal array address width (array depth 2**ADDR_W bytes)
LATENCY, 4, dummy SCLK rising edges between the last address byte and the first read byte
INIT_BYTE, 8'h00, reset/initial content of every array byte (applied at configuration only)

Ports:
clk  input  1  system clock, at least 4x the SCLK frequency
reset  input  1  asynchronous reset, active-high
i_psram_cs  input  1  chip select from memCtrl, active-low
i_psram_sclk  input  1  serial clock from memCtrl
i_psram_data  input  8  DATA[7:0] as driven by memCtrl
o_psram_data  output  8  read data returned to memCtrl
o_psram_oe  output  1  1 = responder drives DATA; the top level builds the tri-state from this
o_busy  output  1  1 while a transaction is in progress (CS low and decoded)
o_last_cmd  output  8  last command byte received
o_err  output  1  sticky flag: unknown command seen

Behaviour:
- Reset (asynchronous, active-high): state IDLE; o_psram_data=0, o_psram_oe=0, o_busy=0, o_last_cmd=0, o_err=0; address register=0. Array contents are not cleared.
- Input synchronization: CS, SCLK and DATA each pass through a 2-flop synchronizer. A SCLK rise or fall is an edge on the synchronized SCLK versus its 1-cycle-delayed copy. DATA is captured from the synchronized bus in the same cycle the rise is detected.
- Protocol: one byte per SCLK rising edge, MSB-first fields.
  - Byte0 = command: 8'h02 WRITE, 8'h03 READ.
  - Bytes 1-3 = 24-bit address ({1'b0, bank[6:0], addr[15:0]}). Only bits [ADDR_W-1:0] are used; the upper bits are ignored (aliasing).
- State machine:
  - IDLE: when synchronized CS falls -> CMD, o_busy=1.
  - CMD: on rise, latch o_last_cmd. 02/03 -> ADDR. Otherwise -> IGNORE with o_err=1.
  - ADDR: three rises fill address[23:0] MSB first. Then WDATA if WRITE, DUMMY if READ.
  - WDATA: each rise writes the byte to array[address], then address+1.
  - DUMMY: count LATENCY rises. At the LATENCY-th rise, prefetch array[address] into o_psram_data, set o_psram_oe=1, address+1 -> RDATA. With LATENCY=0 this happens at the third address rise.
  - RDATA: each SCLK fall loads the next byte (array[address], address+1) one clk after the fall is detected, so the byte is stable before the next rise.
  - IGNORE: stay until CS rises.
- CS rising (synchronized) in any state: next clk -> IDLE, o_psram_oe=0, o_busy=0; any partial address or write is discarded. A byte whose rise coincides with the CS rise is ignored.
- Address wrap: increments modulo 2**ADDR_W, unless the optional feature is enabled.
- Simultaneous SCLK edge and CS rise: CS wins.
- Reset mid-transaction: immediately releases o_psram_oe. Bytes already written stay written.
- Memory-to-memory latency: a read returns bytes written by any earlier, completed transaction.

Optional Feature:
- Macro PSRAM_RESP_PAGE_WRAP_EN.
- Defined: burst address increments wrap within a 1 KiB page (address[9:0] increments, upper bits held), matching PSRAM linear-burst page behaviour.
- Undefined: the full ADDR_W-bit address increments and wraps at the array size.

Test Plan:
- Reset: assert reset mid-idle -> all outputs 0, o_psram_oe=0 within the same cycle.
- Write 0x02, addr 0x00C000, data 8'h14, then read 0x03 at 0x00C000 with LATENCY=4 -> the first returned byte is 8'h14, o_psram_oe=1 after the 4th dummy rise, and o_busy drops 2-3 clk after CS rises.
- Burst write 4 bytes A0..A3 at 2**ADDR_W-2, then read 4 bytes at the same address -> data A0,A1,A2,A3 at addresses FFE,FFF,000,001 (undefined macro). With the macro: 3FE,3FF,000,001 within the page.
- Unknown command 8'h55 followed by 5 bytes -> o_err=1, o_last_cmd=8'h55, array unchanged, o_psram_oe stays 0.
- CS raised after 2 of 3 address bytes, then a full read at 0 -> returns array[0], no corruption; o_busy clears in the same way.
- Bank aliasing: write 8'h7E at {bank=7'h01, addr=16'h0010} -> reading {bank=0, addr=16'h0010} returns 8'h7E (ADDR_W=12).
